// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC job sequencer.
//   state_t  : controller state encoding.
//   A_W/B_W/Z_W : DSP38 operand and result widths.
//   desc_t   : job descriptor latched at accept.
//              DESC_LEN_W bounds the LEN_W parameter of the sequencer (LEN_W <= 16).
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int A_W        = 20;
  localparam int B_W        = 18;
  localparam int Z_W        = 38;
  localparam int SHIFT_W    = 6;
  localparam int DESC_LEN_W = 16;

  typedef struct packed {
    logic [DESC_LEN_W-1:0] len;
    logic [SHIFT_W-1:0]    shift;
    logic                  round;
    logic                  sat;
    logic                  subtract;
    logic                  unsigned_a;
    logic                  unsigned_b;
  } desc_t;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Job-level controller for one DSP38 MULTIPLY_ADD_SUB slice (input registers
// on, output registers off). Accepts a descriptor, streams cfg_len operand
// pairs into the slice while sequencing LOAD_ACC, waits DSP_LAT cycles and
// returns the 38-bit dot product on a valid/ready port.
//
// Ports:
//   clk, lreset          clock, synchronous active-high reset
//   cfg_*                job descriptor handshake (cfg_ready high only in IDLE)
//   op_valid/op_ready    operand pair stream, op_a (20b) x op_b (18b)
//   res_valid/res_ready  result handshake, res_data (38b) straight from dsp_z
//   busy                 controller not idle
//   dsp_*                drive / observe the external DSP38 instance
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = 1
) (
  input  logic              clk,
  input  logic              lreset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [5:0]        cfg_shift,
  input  logic              cfg_round,
  input  logic              cfg_sat,
  input  logic              cfg_subtract,
  input  logic              cfg_unsigned_a,
  input  logic              cfg_unsigned_b,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [A_W-1:0]    op_a,
  input  logic [B_W-1:0]    op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [Z_W-1:0]    res_data,
  output logic              busy,
  output logic [A_W-1:0]    dsp_a,
  output logic [B_W-1:0]    dsp_b,
  input  logic [Z_W-1:0]    dsp_z,
  output logic [2:0]        dsp_feedback,
  output logic [5:0]        dsp_acc_fir,
  output logic              dsp_load_acc,
  output logic              dsp_unsigned_a,
  output logic              dsp_unsigned_b,
  output logic              dsp_saturate,
  output logic [5:0]        dsp_shift_right,
  output logic              dsp_round,
  output logic              dsp_subtract
);

  localparam int LAT_W = (DSP_LAT < 2) ? 1 : $clog2(DSP_LAT + 1);

  state_t             state_reg, state_next;
  desc_t              desc_reg, desc_next;
  logic [LEN_W-1:0]   rem_reg, rem_next;
  logic [LAT_W-1:0]   lat_reg, lat_next;
  logic [A_W-1:0]     a_reg, a_next;
  logic [B_W-1:0]     b_reg, b_next;
  logic               load_reg, load_next;
  logic [Z_W-1:0]     res_data_reg, res_data_next;
  logic               res_valid_reg, res_valid_next;
  logic               first;

  // No pair has been accepted yet while the remaining count still equals the
  // job length, so the "first" flag falls out of the counter directly.
  assign first = (DESC_LEN_W'(rem_reg) == desc_reg.len);

  always_comb begin
    state_next     = state_reg;
    desc_next      = desc_reg;
    rem_next       = rem_reg;
    lat_next       = lat_reg;
    res_data_next  = res_data_reg;
    res_valid_next = res_valid_reg;
    // Operands default to zero so every non-beat cycle adds nothing.
    a_next         = '0;
    b_next         = '0;
    load_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          desc_next.len        = DESC_LEN_W'(cfg_len);
          desc_next.shift      = cfg_shift;
          desc_next.round      = cfg_round;
          desc_next.sat        = cfg_sat;
          desc_next.subtract   = cfg_subtract;
          desc_next.unsigned_a = cfg_unsigned_a;
          desc_next.unsigned_b = cfg_unsigned_b;
          rem_next             = cfg_len;
          res_data_next        = '0;
          if (cfg_len == '0) begin
            state_next     = DONE;
            res_valid_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        // A bubble before the first beat keeps the accumulator cleared.
        load_next = ~first;
        if (op_valid) begin
          a_next   = op_a;
          b_next   = op_b;
          rem_next = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            state_next = DRAIN;
            lat_next   = LAT_W'(DSP_LAT);
          end
        end
      end

      DRAIN: begin
        load_next = 1'b1;
        // The cycle that takes lat to zero is the one where dsp_z carries
        // the final contribution.
        if (lat_reg <= LAT_W'(1)) begin
          lat_next       = '0;
          res_data_next  = dsp_z;
          res_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          lat_next = lat_reg - LAT_W'(1);
        end
      end

      DONE: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (lreset) begin
      state_reg     <= IDLE;
      desc_reg      <= '0;
      rem_reg       <= '0;
      lat_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      load_reg      <= 1'b0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      desc_reg      <= desc_next;
      rem_reg       <= rem_next;
      lat_reg       <= lat_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      load_reg      <= load_next;
      res_data_reg  <= res_data_next;
      res_valid_reg <= res_valid_next;
    end
  end

  // Handshake outputs are forced low while reset is held so that nothing is
  // accepted or presented during the reset cycle itself.
  assign cfg_ready = (state_reg == IDLE) && !lreset;
  assign op_ready  = (state_reg == RUN) && !lreset;
  assign busy      = (state_reg != IDLE) && !lreset;
  assign res_valid = res_valid_reg && !lreset;
  assign res_data  = lreset ? '0 : res_data_reg;

  assign dsp_a           = a_reg;
  assign dsp_b           = b_reg;
  assign dsp_load_acc    = load_reg;
  assign dsp_feedback    = 3'd0;
  assign dsp_acc_fir     = 6'd0;
  assign dsp_unsigned_a  = desc_reg.unsigned_a;
  assign dsp_unsigned_b  = desc_reg.unsigned_b;
  assign dsp_saturate    = desc_reg.sat;
  assign dsp_shift_right = desc_reg.shift;
  assign dsp_round       = desc_reg.round;
  assign dsp_subtract    = desc_reg.subtract;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer paired with a behavioural DSP38 model.
// Expected results are computed from the stimulus and queued at job accept;
// a monitor pops and compares them on each result handshake.
module tb_dsp_mac_sequencer;

  localparam int LEN_W   = 8;
  localparam int DSP_LAT = 1;

  logic              clk;
  logic              lreset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [LEN_W-1:0]  cfg_len;
  logic [5:0]        cfg_shift;
  logic              cfg_round;
  logic              cfg_sat;
  logic              cfg_subtract;
  logic              cfg_unsigned_a;
  logic              cfg_unsigned_b;
  logic              op_valid;
  logic              op_ready;
  logic [19:0]       op_a;
  logic [17:0]       op_b;
  logic              res_valid;
  logic              res_ready;
  logic [37:0]       res_data;
  logic              busy;
  logic [19:0]       dsp_a;
  logic [17:0]       dsp_b;
  logic [37:0]       dsp_z;
  logic [2:0]        dsp_feedback;
  logic [5:0]        dsp_acc_fir;
  logic              dsp_load_acc;
  logic              dsp_unsigned_a;
  logic              dsp_unsigned_b;
  logic              dsp_saturate;
  logic [5:0]        dsp_shift_right;
  logic              dsp_round;
  logic              dsp_subtract;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .DSP_LAT(DSP_LAT)) dut (
    .clk(clk), .lreset(lreset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_sat(cfg_sat),
    .cfg_subtract(cfg_subtract), .cfg_unsigned_a(cfg_unsigned_a),
    .cfg_unsigned_b(cfg_unsigned_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_z(dsp_z),
    .dsp_feedback(dsp_feedback), .dsp_acc_fir(dsp_acc_fir),
    .dsp_load_acc(dsp_load_acc), .dsp_unsigned_a(dsp_unsigned_a),
    .dsp_unsigned_b(dsp_unsigned_b), .dsp_saturate(dsp_saturate),
    .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round),
    .dsp_subtract(dsp_subtract)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- arithmetic
  function automatic logic signed [63:0] prod(input logic [19:0] a, input logic [17:0] b,
                                              input logic ua, input logic ub);
    logic signed [63:0] xa, xb;
    xa = ua ? {44'd0, a} : {{44{a[19]}}, a};
    xb = ub ? {46'd0, b} : {{46{b[17]}}, b};
    return xa * xb;
  endfunction

  function automatic logic [37:0] post(input logic signed [63:0] s, input logic [5:0] sh,
                                       input logic rnd, input logic sat);
    logic signed [63:0] v;
    v = s;
    if (rnd && sh != 6'd0) v = v + (64'sd1 <<< (sh - 6'd1));
    v = v >>> sh;
    if (sat) begin
      if (v > 64'sd137438953471) v = 64'sd137438953471;
      else if (v < -64'sd137438953472) v = -64'sd137438953472;
    end
    return v[37:0];
  endfunction

  // Behavioural DSP38: the sequencer's registered dsp_a/dsp_b act as the
  // input register, Z is the post-processed running sum (no output register).
  logic signed [63:0] acc_reg = 64'sd0;
  logic signed [63:0] sum_comb;
  always_comb begin
    sum_comb = prod(dsp_a, dsp_b, dsp_unsigned_a, dsp_unsigned_b);
    if (dsp_subtract) sum_comb = -sum_comb;
    if (dsp_load_acc) sum_comb = acc_reg + sum_comb;
  end
  assign dsp_z = post(sum_comb, dsp_shift_right, dsp_round, dsp_saturate);
  always @(posedge clk) acc_reg <= sum_comb;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [37:0] exp_q[$];
  int jobs_done = 0;

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      check_eq("sb_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check_eq("res_data", 64'(res_data), 64'(e));
        $display("job %0d: res_data=0x%0h expected=0x%0h", jobs_done, res_data, e);
        jobs_done++;
      end
    end
  end

  function automatic logic [10:0] dsp_cfg_now();
    return {dsp_unsigned_a, dsp_unsigned_b, dsp_saturate, dsp_shift_right, dsp_round, dsp_subtract};
  endfunction

  // ---------------------------------------------------------------- stimulus
  logic [19:0] pa [256];
  logic [17:0] pb [256];

  task automatic run_job(input int n, input logic [5:0] sh, input logic rnd, input logic sat,
                         input logic sub, input logic ua, input logic ub,
                         input logic bubbles, input int hold, output int cyc_out);
    logic signed [63:0] sum;
    logic [10:0] cfgv;
    int steps[$];
    int k;
    int cyc;
    logic seen_pair;

    res_ready = (hold == 0);
    k = 0;
    @(negedge clk);
    while (!cfg_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("cfg_ready_before_job", 64'(cfg_ready), 64'd1);

    sum = 64'sd0;
    for (int i = 0; i < n; i++) begin
      if (sub) sum = sum - prod(pa[i], pb[i], ua, ub);
      else     sum = sum + prod(pa[i], pb[i], ua, ub);
    end
    exp_q.push_back(post(sum, sh, rnd, sat));
    cfgv = {ua, ub, sat, sh, rnd, sub};

    cfg_valid = 1'b1; cfg_len = LEN_W'(n); cfg_shift = sh; cfg_round = rnd;
    cfg_sat = sat; cfg_subtract = sub; cfg_unsigned_a = ua; cfg_unsigned_b = ub;
    @(negedge clk);
    cfg_valid = 1'b0;
    cyc = 1;
    check_eq("dsp_cfg_at_accept", 64'(dsp_cfg_now()), 64'(cfgv));
    check_eq("busy_after_accept", 64'(busy), 64'd1);

    if (n > 0) begin
      for (int i = 0; i < n; i++) begin
        if (bubbles) steps.push_back(-1);
        steps.push_back(i);
      end
      seen_pair = 1'b0;
      foreach (steps[s]) begin
        check_eq("op_ready_run", 64'(op_ready), 64'd1);
        if (steps[s] < 0) begin
          op_valid = 1'b0; op_a = 20'($urandom); op_b = 18'($urandom);
        end else begin
          op_valid = 1'b1; op_a = pa[steps[s]]; op_b = pb[steps[s]];
        end
        @(negedge clk);
        cyc++;
        if (steps[s] < 0) begin
          check_eq("bubble_dsp_ab", 64'({dsp_a, dsp_b}), 64'd0);
          check_eq("bubble_load_acc", 64'(dsp_load_acc), 64'(seen_pair));
        end else begin
          check_eq("beat_dsp_ab", 64'({dsp_a, dsp_b}), 64'({pa[steps[s]], pb[steps[s]]}));
          check_eq("beat_load_acc", 64'(dsp_load_acc), 64'(steps[s] != 0));
          seen_pair = 1'b1;
        end
        check_eq("dsp_cfg_run", 64'(dsp_cfg_now()), 64'(cfgv));
      end
      op_valid = 1'b0;
      check_eq("op_ready_drain", 64'(op_ready), 64'd0);
      check_eq("cfg_ready_drain", 64'(cfg_ready), 64'd0);
      k = 0;
      while (!res_valid && k < 20) begin
        @(negedge clk);
        k++;
        cyc++;
      end
      check_eq("drain_latency", 64'(k), 64'(DSP_LAT));
      check_eq("res_valid_cycle", 64'(cyc), 64'(steps.size() + DSP_LAT + 1));
      check_eq("dsp_cfg_done", 64'(dsp_cfg_now()), 64'(cfgv));
    end else begin
      check_eq("len0_res_valid", 64'(res_valid), 64'd1);
      check_eq("len0_dsp_ab", 64'({dsp_a, dsp_b, dsp_load_acc}), 64'd0);
    end

    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        check_eq("hold_res_valid", 64'(res_valid), 64'd1);
        check_eq("hold_res_data", 64'(res_data), 64'(exp_q[0]));
        check_eq("hold_cfg_ready", 64'(cfg_ready), 64'd0);
        cfg_valid = 1'b1; cfg_len = LEN_W'(7); cfg_shift = 6'd9;
        @(negedge clk);
        cyc++;
      end
      cfg_valid = 1'b0;
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end

    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
      cyc++;
    end
    check_eq("idle_after_job", 64'({busy, res_valid, cfg_ready}), 64'b001);
    check_eq("dsp_cfg_idle", 64'(dsp_cfg_now()), 64'(cfgv));
    res_ready = 1'b0;
    cyc_out = cyc;
  endtask

  initial begin
    int cyc;
    lreset = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_shift = '0; cfg_round = 1'b0;
    cfg_sat = 1'b0; cfg_subtract = 1'b0; cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("reset_handshakes", 64'({cfg_ready, op_ready, busy, res_valid}), 64'd0);
    check_eq("reset_res_data", 64'(res_data), 64'd0);
    lreset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_cfg_ready", 64'(cfg_ready), 64'd1);
    check_eq("post_reset_dsp", 64'({dsp_a, dsp_b, dsp_load_acc, dsp_feedback, dsp_acc_fir}), 64'd0);
    check_eq("post_reset_dsp_cfg", 64'(dsp_cfg_now()), 64'd0);

    // signed dot product 2*3 + 4*5 + (-1)*7
    pa[0] = 20'd2; pb[0] = 18'd3; pa[1] = 20'd4; pb[1] = 18'd5; pa[2] = 20'hFFFFF; pb[2] = 18'd7;
    run_job(3, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, cyc);

    // same pairs with bubbles (including one before the first beat), subtract
    run_job(3, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, cyc);

    // empty job
    run_job(0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, cyc);

    // result held in DONE with a spurious descriptor offered
    pa[0] = 20'd10; pb[0] = 18'h3FFFD; pa[1] = 20'd7; pb[1] = 18'd7;
    run_job(2, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, cyc);

    // unsigned all-ones, shift/round/saturate config
    pa[0] = 20'hFFFFF; pb[0] = 18'h3FFFF; pa[1] = 20'hFFFFF; pb[1] = 18'h3FFFF;
    run_job(2, 6'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, cyc);

    // abort after 2 of 5 pairs
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = LEN_W'(5); cfg_shift = 6'd0; cfg_round = 1'b0;
    cfg_sat = 1'b0; cfg_subtract = 1'b0; cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_a = 20'(i + 5); op_b = 18'(i + 9);
      @(negedge clk);
    end
    check_eq("abort_busy_before", 64'(busy), 64'd1);
    op_valid = 1'b0;
    lreset = 1'b1;
    @(negedge clk);
    check_eq("abort_reset_cycle", 64'({busy, res_valid, cfg_ready, op_ready}), 64'd0);
    lreset = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", 64'({busy, res_valid, cfg_ready}), 64'b001);
    check_eq("abort_dsp_cleared", 64'({dsp_a, dsp_b, dsp_load_acc}), 64'd0);

    pa[0] = 20'd3; pb[0] = 18'd3;
    run_job(1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, cyc);

    // single pair with res_ready high: accept to IDLE in 4 cycles
    pa[0] = 20'hFFFFB; pb[0] = 18'd6;
    run_job(1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, cyc);
    check_eq("b2b_accept_to_idle", 64'(cyc), 64'(DSP_LAT + 3));

    // maximum length, random signed operands, saturating
    for (int i = 0; i < 255; i++) begin
      pa[i] = 20'($urandom);
      pb[i] = 18'($urandom);
    end
    run_job(255, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, cyc);

    repeat (2) @(negedge clk);
    check_eq("jobs_completed", 64'(jobs_done), 64'd8);
    check_eq("sb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
